// File: rtl/multiport_regfile.sv
// Integer register file: NREAD combinational read ports, NWRITE write ports, x0 hardwired to zero.
// Keeps a per-register busy scoreboard. Define REGFILE_BYPASS_EN to forward same-cycle writes to reads.
module multiport_regfile #(
    parameter int XLEN   = 32,
    parameter int NREGS  = 32,
    parameter int NREAD  = 2,
    parameter int NWRITE = 1,
    localparam int AW    = $clog2(NREGS)
) (
    input  logic                     clock,
    input  logic                     reset,
    input  logic [NWRITE-1:0]        WB_reg_wr_enb,
    input  logic [NWRITE*AW-1:0]     WB_reg_write_addr,
    input  logic [NWRITE*XLEN-1:0]   WB_reg_write_data,
    input  logic [NREAD*AW-1:0]      ID_reg_read_addr,
    output logic [NREAD*XLEN-1:0]    ID_reg_read_data,
    output logic [NREAD-1:0]         ID_reg_busy,
    input  logic                     ID_sb_set_enb,
    input  logic [AW-1:0]            ID_sb_set_addr
);

    logic [XLEN-1:0]  regs_q [NREGS];
    logic [XLEN-1:0]  regs_d [NREGS];
    logic [NREGS-1:0] busy_q;
    logic [NREGS-1:0] busy_d;

    logic [AW-1:0]    wr_addr [NWRITE];
    logic [XLEN-1:0]  wr_data [NWRITE];
    logic [AW-1:0]    rd_addr [NREAD];

    for (genvar p = 0; p < NWRITE; p++) begin : g_wr
        assign wr_addr[p] = WB_reg_write_addr[p*AW +: AW];
        assign wr_data[p] = WB_reg_write_data[p*XLEN +: XLEN];
    end

    for (genvar r = 0; r < NREAD; r++) begin : g_rd
        assign rd_addr[r] = ID_reg_read_addr[r*AW +: AW];
    end

    // Ascending port order lets the highest-numbered writer win; set is applied last so it beats a clear.
    always_comb begin
        regs_d = regs_q;
        busy_d = busy_q;
        for (int p = 0; p < NWRITE; p++) begin
            if (WB_reg_wr_enb[p] && (wr_addr[p] != '0)) begin
                regs_d[wr_addr[p]] = wr_data[p];
                busy_d[wr_addr[p]] = 1'b0;
            end
        end
        if (ID_sb_set_enb && (ID_sb_set_addr != '0)) begin
            busy_d[ID_sb_set_addr] = 1'b1;
        end
        busy_d[0] = 1'b0;
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            regs_q <= '{default: '0};
            busy_q <= '0;
        end else begin
            regs_q <= regs_d;
            busy_q <= busy_d;
        end
    end

    always_comb begin
        ID_reg_read_data = '0;
        ID_reg_busy      = '0;
        for (int r = 0; r < NREAD; r++) begin
            ID_reg_read_data[r*XLEN +: XLEN] = regs_q[rd_addr[r]];
            ID_reg_busy[r]                   = busy_q[rd_addr[r]];
`ifdef REGFILE_BYPASS_EN
            // Reset must still force zeros even if a write is presented.
            for (int p = 0; p < NWRITE; p++) begin
                if (!reset && WB_reg_wr_enb[p] && (wr_addr[p] == rd_addr[r]) && (rd_addr[r] != '0)) begin
                    ID_reg_read_data[r*XLEN +: XLEN] = wr_data[p];
                    ID_reg_busy[r]                   = 1'b0;
                end
            end
`endif
        end
    end

endmodule

// File: tb/tb_multiport_regfile.sv
// Self-checking bench for multiport_regfile (2 read / 2 write ports) against an array-based reference model.
module tb_multiport_regfile;

    localparam int XLEN   = 32;
    localparam int NREGS  = 32;
    localparam int NREAD  = 2;
    localparam int NWRITE = 2;
    localparam int AW     = 5;

    logic                   clock = 1'b0;
    logic                   reset;
    logic [NWRITE-1:0]      wen;
    logic [NWRITE*AW-1:0]   waddr;
    logic [NWRITE*XLEN-1:0] wdata;
    logic [NREAD*AW-1:0]    raddr;
    logic [NREAD*XLEN-1:0]  rdata;
    logic [NREAD-1:0]       rbusy;
    logic                   sen;
    logic [AW-1:0]          saddr;

    int n_cmp = 0;
    int n_err = 0;

    logic [XLEN-1:0] mdl_reg  [NREGS];
    logic            mdl_busy [NREGS];

    multiport_regfile #(.XLEN(XLEN), .NREGS(NREGS), .NREAD(NREAD), .NWRITE(NWRITE)) dut (
        .clock             (clock),
        .reset             (reset),
        .WB_reg_wr_enb     (wen),
        .WB_reg_write_addr (waddr),
        .WB_reg_write_data (wdata),
        .ID_reg_read_addr  (raddr),
        .ID_reg_read_data  (rdata),
        .ID_reg_busy       (rbusy),
        .ID_sb_set_enb     (sen),
        .ID_sb_set_addr    (saddr)
    );

    always #5 clock = ~clock;

    task automatic chk(input string tag, input logic [XLEN-1:0] obs, input logic [XLEN-1:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", tag, obs, exp, $time);
        end
    endtask

    task automatic mdl_clear();
        for (int i = 0; i < NREGS; i++) begin
            mdl_reg[i]  = '0;
            mdl_busy[i] = 1'b0;
        end
    endtask

    task automatic idle();
        wen = '0; waddr = '0; wdata = '0; sen = 1'b0; saddr = '0;
    endtask

    task automatic set_rd(input int a0, input int a1);
        raddr = {a1[AW-1:0], a0[AW-1:0]};
    endtask

    task automatic set_wr(input int p, input int a, input logic [XLEN-1:0] d);
        wen[p]              = 1'b1;
        waddr[p*AW +: AW]   = a[AW-1:0];
        wdata[p*XLEN +: XLEN] = d;
    endtask

    // Expected read results follow the architectural rules directly from the model arrays.
    task automatic check_reads(input string tag);
        for (int r = 0; r < NREAD; r++) begin
            int a;
            logic [XLEN-1:0] ed;
            logic eb;
            a  = int'(raddr[r*AW +: AW]);
            ed = reset ? '0 : mdl_reg[a];
            eb = reset ? 1'b0 : mdl_busy[a];
`ifdef REGFILE_BYPASS_EN
            for (int p = 0; p < NWRITE; p++) begin
                if (!reset && wen[p] && int'(waddr[p*AW +: AW]) == a && a != 0) begin
                    ed = wdata[p*XLEN +: XLEN];
                    eb = 1'b0;
                end
            end
`endif
            chk($sformatf("%s_data%0d", tag, r), rdata[r*XLEN +: XLEN], ed);
            chk($sformatf("%s_busy%0d", tag, r), {31'b0, rbusy[r]}, {31'b0, eb});
        end
    endtask

    task automatic tick();
        @(posedge clock);
        if (!reset) begin
            for (int p = 0; p < NWRITE; p++) begin
                int a;
                a = int'(waddr[p*AW +: AW]);
                if (wen[p] && a != 0) begin
                    mdl_reg[a]  = wdata[p*XLEN +: XLEN];
                    mdl_busy[a] = 1'b0;
                end
            end
            if (sen && saddr != '0) mdl_busy[saddr] = 1'b1;
        end
        #1;
    endtask

    initial begin
        mdl_clear();
        idle();
        raddr = '0;
        reset = 1'b1;
        #3;
        set_rd(9, 31);
        #1 check_reads("in_reset");
        #8 reset = 1'b0;
        tick();

        // Every address reads zero and not busy after reset.
        for (int i = 0; i < NREGS; i++) begin
            set_rd(i, NREGS - 1 - i);
            #1;
            chk("rst_rd0", rdata[31:0], 32'h0);
            chk("rst_rd1", rdata[63:32], 32'h0);
            chk("rst_busy", {30'b0, rbusy}, 32'h0);
        end
        tick();

        set_wr(0, 9, 32'hDEADBEEF);
        tick();
        idle();
        set_rd(9, 0);
        #1;
        chk("x9_wr", rdata[31:0], 32'hDEADBEEF);
        chk("x0_rd", rdata[63:32], 32'h0);
        set_wr(0, 0, 32'h1234);
        tick();
        idle();
        set_rd(0, 0);
        #1 chk("x0_discard", rdata[31:0], 32'h0);

        set_wr(0, 5, 32'h11);
        set_wr(1, 5, 32'h22);
        tick();
        idle();
        set_rd(5, 5);
        #1 chk("x5_prio", rdata[63:32], 32'h22);

        sen = 1'b1; saddr = 5'd7;
        tick();
        idle();
        set_rd(7, 0);
        #1;
        chk("x7_set", {31'b0, rbusy[0]}, 32'h1);
        chk("x0_nobusy", {31'b0, rbusy[1]}, 32'h0);
        tick();
        set_wr(0, 7, 32'h77);
        sen = 1'b1; saddr = 5'd7;
        tick();
        idle();
        #1 chk("x7_setwins", {31'b0, rbusy[0]}, 32'h1);
        set_wr(1, 7, 32'h78);
        tick();
        idle();
        #1 chk("x7_clr", {31'b0, rbusy[0]}, 32'h0);

        set_rd(3, 3);
        set_wr(0, 3, 32'hCAFEF00D);
        #1;
`ifdef REGFILE_BYPASS_EN
        chk("byp_data", rdata[31:0], 32'hCAFEF00D);
`else
        chk("byp_data", rdata[31:0], 32'h0);
`endif
        chk("byp_busy", {31'b0, rbusy[0]}, 32'h0);
        tick();
        idle();

        for (int c = 0; c < 400; c++) begin
            wen   = 2'($urandom);
            waddr = {5'($urandom_range(0, 7)), 5'($urandom_range(0, 7))};
            if (c % 5 == 0) waddr = 10'($urandom);
            wdata = {$urandom, $urandom};
            sen   = 1'($urandom);
            saddr = 5'($urandom_range(0, 7));
            raddr = {5'($urandom_range(0, 7)), 5'($urandom_range(0, 7))};
            #1 check_reads("rnd");
            tick();
        end
        idle();

        set_wr(0, 1, 32'hFFFFFFFF);
        sen = 1'b1; saddr = 5'd1;
        tick();
        idle();
        set_rd(1, 1);
        #1;
        chk("x1_pre", rdata[31:0], 32'hFFFFFFFF);
        chk("x1_busy_pre", {31'b0, rbusy[0]}, 32'h1);
        #1 reset = 1'b1;
        mdl_clear();
        #1;
        chk("arst_data", rdata[31:0], 32'h0);
        chk("arst_busy", {30'b0, rbusy}, 32'h0);
        set_wr(0, 2, 32'hABCD);
        sen = 1'b1; saddr = 5'd2;
        #1 check_reads("arst_wr");
        tick();
        #2 reset = 1'b0;
        idle();
        set_rd(2, 1);
        #1;
        chk("drop_data", rdata[31:0], 32'h0);
        chk("drop_busy", {30'b0, rbusy}, 32'h0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
